// File: rtl/set_issuer_pkg.sv
// set_issuer_pkg: shared state encoding, range limits and field packing for set_job_issuer.
package set_issuer_pkg;

    typedef enum logic [2:0] {IDLE, CHECK, LAUNCH, RUN, DONE} state_t;

    localparam int FIELD_W   = 4;
    localparam int CIRCLES   = 3;
    localparam int CENTRAL_W = 2 * FIELD_W * CIRCLES;
    localparam int RADIUS_W  = FIELD_W * CIRCLES;
    localparam int MODE_W    = 2;
    localparam int COUNT_W   = 8;

    localparam logic [FIELD_W-1:0] COORD_MIN = 4'd1;
    localparam logic [FIELD_W-1:0] COORD_MAX = 4'd8;
    localparam logic [FIELD_W-1:0] RAD_MAX   = 4'd8;

    // Circle 0 occupies the most significant fields of both packed buses.
    function automatic logic [FIELD_W-1:0] coord_x(input logic [CENTRAL_W-1:0] c, input int i);
        return c[CENTRAL_W-1-2*FIELD_W*i -: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] coord_y(input logic [CENTRAL_W-1:0] c, input int i);
        return c[CENTRAL_W-1-FIELD_W*(2*i+1) -: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] radius_of(input logic [RADIUS_W-1:0] r, input int i);
        return r[RADIUS_W-1-FIELD_W*i -: FIELD_W];
    endfunction

    function automatic logic [CIRCLES-1:0] used_mask(input logic [MODE_W-1:0] mode);
        return mode == 2'b00 ? 3'b001 : mode == 2'b11 ? 3'b111 : 3'b011;
    endfunction

endpackage

// File: rtl/set_job_issuer_if.sv
// set_job_issuer_if: job, counter and result ports of set_job_issuer.
// With SET_JOB_CHECK_EN defined it also carries job_expected / res_match.
interface set_job_issuer_if
    import set_issuer_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic                 job_valid;
    logic                 job_ready;
    logic [CENTRAL_W-1:0] job_central;
    logic [RADIUS_W-1:0]  job_radius;
    logic [MODE_W-1:0]    job_mode;
    logic [TAG_W-1:0]     job_tag;
    logic                 set_en;
    logic [CENTRAL_W-1:0] set_central;
    logic [RADIUS_W-1:0]  set_radius;
    logic [MODE_W-1:0]    set_mode;
    logic                 set_busy;
    logic                 set_valid;
    logic [COUNT_W-1:0]   set_candidate;
    logic                 res_valid;
    logic                 res_ready;
    logic [COUNT_W-1:0]   res_count;
    logic [TAG_W-1:0]     res_tag;
    logic                 res_error;
    logic                 res_timeout;
`ifdef SET_JOB_CHECK_EN
    logic [COUNT_W-1:0]   job_expected;
    logic                 res_match;
`endif

    modport master (
        input  job_valid, job_central, job_radius, job_mode, job_tag,
        input  set_busy, set_valid, set_candidate, res_ready,
`ifdef SET_JOB_CHECK_EN
        input  job_expected,
        output res_match,
`endif
        output job_ready, set_en, set_central, set_radius, set_mode,
        output res_valid, res_count, res_tag, res_error, res_timeout
    );

    modport slave (
        output job_valid, job_central, job_radius, job_mode, job_tag,
        output set_busy, set_valid, set_candidate, res_ready,
`ifdef SET_JOB_CHECK_EN
        output job_expected,
        input  res_match,
`endif
        input  job_ready, set_en, set_central, set_radius, set_mode,
        input  res_valid, res_count, res_tag, res_error, res_timeout
    );

endinterface

// File: rtl/set_job_range_chk.sv
// set_job_range_chk: combinational legality check of the circles a job mode actually uses.
module set_job_range_chk
    import set_issuer_pkg::*;
(
    input  logic [CENTRAL_W-1:0] central,
    input  logic [RADIUS_W-1:0]  radius,
    input  logic [MODE_W-1:0]    mode,
    output logic                 legal
);
    logic [CIRCLES-1:0] used;

    always_comb begin
        used  = used_mask(mode);
        legal = 1'b1;
        for (int i = 0; i < CIRCLES; i++) begin
            if (used[i] && !(coord_x(central, i) >= COORD_MIN && coord_x(central, i) <= COORD_MAX &&
                             coord_y(central, i) >= COORD_MIN && coord_y(central, i) <= COORD_MAX &&
                             radius_of(radius, i) <= RAD_MAX))
                legal = 1'b0;
        end
    end

endmodule

// File: rtl/set_job_issuer.sv
// set_job_issuer: accepts circle-set jobs, launches them on the point counter and returns one result each.
// Optional SET_JOB_CHECK_EN adds job_expected / res_match comparison.
module set_job_issuer
    import set_issuer_pkg::*;
#(
    parameter int TIMEOUT_CYC = 80,
    parameter int TAG_W       = 4
)(
    input logic              clk,
    input logic              rst,
    set_job_issuer_if.master bus
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 2);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYC);

    state_t           state, state_n;
    logic             legal;
    logic [WD_W-1:0]  wd;
    logic [TAG_W-1:0] tag_q;
    logic             accept, expired;

    set_job_range_chk u_chk (
        .central (bus.set_central),
        .radius  (bus.set_radius),
        .mode    (bus.set_mode),
        .legal   (legal)
    );

    assign accept      = state == IDLE && bus.job_valid;
    assign expired     = state == RUN && wd == WD_LIM;
    assign bus.res_tag = tag_q;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n       = state;
        bus.job_ready = state == IDLE && !rst;
        bus.set_en    = state == LAUNCH;
        bus.res_valid = state == DONE;
        unique case (state)
            IDLE:    state_n = bus.job_valid ? CHECK : IDLE;
            CHECK:   state_n = legal ? LAUNCH : DONE;
            LAUNCH:  state_n = RUN;
            RUN:     state_n = bus.set_valid || expired ? DONE : RUN;
            DONE:    state_n = bus.res_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // Counter inputs stay frozen from acceptance until the next job is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.set_central <= '0;
            bus.set_radius  <= '0;
            bus.set_mode    <= '0;
            bus.res_count   <= '0;
            bus.res_error   <= 1'b0;
            bus.res_timeout <= 1'b0;
            tag_q           <= '0;
            wd              <= '0;
        end else begin
            if (accept) begin
                bus.set_central <= bus.job_central;
                bus.set_radius  <= bus.job_radius;
                bus.set_mode    <= bus.job_mode;
                bus.res_count   <= '0;
                bus.res_error   <= 1'b0;
                bus.res_timeout <= 1'b0;
                tag_q           <= bus.job_tag;
            end
            if (state == CHECK && !legal)
                bus.res_error <= 1'b1;
            if (state == LAUNCH)
                wd <= '0;
            else if (state == RUN && wd != '1)
                wd <= wd + 1'b1;
            // A strobe arriving on the expiry cycle still counts as a real result.
            if (state == RUN && bus.set_valid)
                bus.res_count <= bus.set_candidate;
            else if (expired)
                bus.res_timeout <= 1'b1;
        end
    end

`ifdef SET_JOB_CHECK_EN
    logic [COUNT_W-1:0] exp_q;

    always_ff @(posedge clk) begin
        if (rst)
            exp_q <= '0;
        else if (accept)
            exp_q <= bus.job_expected;
    end

    assign bus.res_match = bus.res_valid && !bus.res_error && !bus.res_timeout && bus.res_count == exp_q;
`endif

endmodule

// File: tb/tb_set_job_issuer.sv
// tb_set_job_issuer: randomized and directed jobs against a geometric reference model of the counter.
module tb_set_job_issuer;

    localparam int TIMEOUT_CYC = 80;
    localparam int TAG_W       = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    set_job_issuer_if #(.TAG_W(TAG_W)) bus ();

    set_job_issuer #(.TIMEOUT_CYC(TIMEOUT_CYC), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int stub_lat = 66;
    bit stub_hang = 0;
    bit spur = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fld(input logic [23:0] v, input int sh);
        return int'((v >> sh) & 24'hF);
    endfunction

    function automatic bit model_legal(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        int n = (m == 2'b00) ? 1 : (m == 2'b11) ? 3 : 2;
        for (int i = 0; i < n; i++) begin
            int x = fld(c, 20 - 8 * i);
            int y = fld(c, 16 - 8 * i);
            int rr = fld({12'd0, r}, 8 - 4 * i);
            if (x < 1 || x > 8 || y < 1 || y > 8 || rr > 8) return 0;
        end
        return 1;
    endfunction

    function automatic int model_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        int n = 0;
        for (int px = 1; px <= 8; px++)
            for (int py = 1; py <= 8; py++) begin
                int k = 0;
                bit b[3];
                for (int i = 0; i < 3; i++) begin
                    int dx = px - fld(c, 20 - 8 * i);
                    int dy = py - fld(c, 16 - 8 * i);
                    int rr = fld({12'd0, r}, 8 - 4 * i);
                    b[i] = dx * dx + dy * dy <= rr * rr;
                    k += int'(b[i]);
                end
                case (m)
                    2'b00:   n += int'(b[0]);
                    2'b01:   n += int'(b[0] && b[1]);
                    2'b10:   n += int'(b[0] ^ b[1]);
                    default: n += int'(k == 2);
                endcase
            end
        return n;
    endfunction

    // Stub point counter: answers stub_lat cycles after launch using whatever mode is presented then.
    initial begin
        int cd = 0;
        bit act = 0;
        bus.set_valid = 0;
        bus.set_busy = 0;
        bus.set_candidate = 0;
        forever begin
            @(negedge clk);
            bus.set_valid = 0;
            if (rst) begin
                act = 0;
                bus.set_busy = 0;
            end else if (act) begin
                if (cd == 0) begin
                    bus.set_valid = 1;
                    bus.set_candidate = 8'(model_count(bus.set_central, bus.set_radius, bus.set_mode));
                    bus.set_busy = 0;
                    act = 0;
                end else cd--;
            end else if (bus.set_en && !stub_hang) begin
                act = 1;
                cd = stub_lat;
                bus.set_busy = 1;
            end else if (spur) begin
                bus.set_valid = 1;
                bus.set_candidate = 8'hAA;
            end
        end
    end

    task automatic run_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                           input logic [3:0] tag, input int lat, input bit hang, input int stall,
                           input logic [7:0] expv, output int got);
        bit legal, tmo;
        int cnt, cyc, en_cyc, pulses, bad, hold_bad;
        logic [7:0] cnt_q;
        logic [3:0] tag_q;
        legal = model_legal(c, r, m);
        tmo = legal && (hang || lat > TIMEOUT_CYC);
        cnt = (legal && !tmo) ? model_count(c, r, m) : 0;
        stub_lat = lat;
        stub_hang = hang;
        @(negedge clk);
        check("job_ready_idle", bus.job_ready, 1);
        bus.job_valid = 1;
        bus.job_central = c;
        bus.job_radius = r;
        bus.job_mode = m;
        bus.job_tag = tag;
`ifdef SET_JOB_CHECK_EN
        bus.job_expected = expv;
`endif
        @(negedge clk);
        bus.job_valid = 0;
        bus.job_central = 24'($urandom);
        bus.job_radius = 12'($urandom);
        bus.job_mode = 2'($urandom);
        bus.job_tag = 4'($urandom);
        cyc = 1;
        en_cyc = -1;
        pulses = 0;
        bad = 0;
        while (!bus.res_valid && cyc < 300) begin
            if (bus.set_en) begin
                pulses++;
                if (en_cyc < 0) en_cyc = cyc;
            end
            if (bus.job_ready || bus.set_central !== c || bus.set_radius !== r || bus.set_mode !== m) bad++;
            @(negedge clk);
            cyc++;
        end
        check("res_valid_seen", bus.res_valid, 1);
        check("set_en_pulses", pulses, legal ? 1 : 0);
        check("set_inputs_held", bad, 0);
        if (!legal) check("error_cycle", cyc, 2);
        else begin
            check("set_en_cycle", en_cyc, 2);
            check(tmo ? "timeout_cycle" : "result_cycle", cyc - en_cyc, tmo ? TIMEOUT_CYC + 2 : lat + 2);
        end
        check("res_count", bus.res_count, cnt);
        check("res_tag", bus.res_tag, tag);
        check("res_error", bus.res_error, !legal);
        check("res_timeout", bus.res_timeout, tmo);
`ifdef SET_JOB_CHECK_EN
        check("res_match", bus.res_match, legal && !tmo && int'(expv) == cnt);
`endif
        got = int'(bus.res_count);
        cnt_q = bus.res_count;
        tag_q = bus.res_tag;
        hold_bad = 0;
        bus.job_valid = 1;
        spur = 1;
        repeat (stall) begin
            @(negedge clk);
            if (bus.job_ready || !bus.res_valid || bus.res_count !== cnt_q || bus.res_tag !== tag_q ||
                bus.res_error !== !legal || bus.res_timeout !== tmo) hold_bad++;
        end
        check("done_hold", hold_bad, 0);
        spur = 0;
        bus.res_ready = 1;
        @(negedge clk);
        bus.res_ready = 0;
        bus.job_valid = 0;
        check("res_valid_drop", bus.res_valid, 0);
        check("job_ready_back", bus.job_ready, 1);
    endtask

    function automatic logic [3:0] rnd_coord();
        return ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
    endfunction

    function automatic logic [3:0] rnd_rad();
        return ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
    endfunction

    initial begin
        int got, bad;
        bus.job_valid = 0;
        bus.job_central = 0;
        bus.job_radius = 0;
        bus.job_mode = 0;
        bus.job_tag = 0;
        bus.res_ready = 0;
`ifdef SET_JOB_CHECK_EN
        bus.job_expected = 0;
`endif
        repeat (2) @(negedge clk);
        check("rst_job_ready", bus.job_ready, 0);
        check("rst_set_en", bus.set_en, 0);
        check("rst_set_central", bus.set_central, 0);
        check("rst_set_radius", bus.set_radius, 0);
        check("rst_set_mode", bus.set_mode, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_count", bus.res_count, 0);
        check("rst_res_tag", bus.res_tag, 0);
        check("rst_res_error", bus.res_error, 0);
        check("rst_res_timeout", bus.res_timeout, 0);
        rst = 0;

        run_job(24'h440000, 12'h200, 2'b00, 4'h1, 66, 0, 0, 8'd13, got);
        check("c0_r2_count", got, 13);
        run_job(24'h444400, 12'h220, 2'b01, 4'h2, 66, 0, 2, 8'd13, got);
        check("and_count", got, 13);
        run_job(24'h444400, 12'h220, 2'b10, 4'h3, 66, 0, 1, 8'd5, got);
        check("xor_count", got, 0);
        run_job(24'h940000, 12'h200, 2'b00, 4'h4, 66, 0, 0, 8'd0, got);
        run_job(24'h440000, 12'h200, 2'b00, 4'h5, 0, 1, 0, 8'd0, got);
        run_job(24'h440000, 12'h200, 2'b00, 4'h6, 10, 0, 5, 8'd13, got);
        run_job(24'h440000, 12'h200, 2'b00, 4'h7, TIMEOUT_CYC, 0, 0, 8'd13, got);
        run_job(24'h440000, 12'h200, 2'b00, 4'h8, TIMEOUT_CYC + 1, 0, 0, 8'd0, got);
        run_job(24'h44F000, 12'h2F0, 2'b00, 4'h9, 3, 0, 0, 8'd13, got);
        run_job(24'h110800, 12'h880, 2'b01, 4'hA, 3, 0, 0, 8'd0, got);
        run_job(24'h110800, 12'h890, 2'b01, 4'hB, 3, 0, 0, 8'd0, got);
        run_job(24'h453466, 12'h333, 2'b11, 4'hC, 20, 0, 0, 8'd0, got);
        run_job(24'h453406, 12'h333, 2'b11, 4'hD, 20, 0, 0, 8'd0, got);

        stub_lat = 66;
        stub_hang = 0;
        @(negedge clk);
        bus.job_valid = 1;
        bus.job_central = 24'h440000;
        bus.job_radius = 12'h200;
        bus.job_mode = 2'b00;
        bus.job_tag = 4'hE;
        @(negedge clk);
        bus.job_valid = 0;
        repeat (20) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("mid_rst_job_ready", bus.job_ready, 0);
        check("mid_rst_res_valid", bus.res_valid, 0);
        check("mid_rst_set_en", bus.set_en, 0);
        check("mid_rst_set_central", bus.set_central, 0);
        check("mid_rst_set_radius", bus.set_radius, 0);
        check("mid_rst_res_tag", bus.res_tag, 0);
        @(negedge clk);
        rst = 0;
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.res_valid || bus.set_en || !bus.job_ready) bad++;
        end
        check("abandoned_job_silent", bad, 0);
        run_job(24'h440000, 12'h200, 2'b00, 4'hF, 66, 0, 0, 8'd13, got);

        for (int n = 0; n < 24; n++) begin
            logic [23:0] c;
            logic [11:0] r;
            logic [1:0] m;
            logic [7:0] e;
            c = {rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord()};
            r = {rnd_rad(), rnd_rad(), rnd_rad()};
            m = 2'($urandom);
            e = $urandom_range(0, 1) ? 8'(model_count(c, r, m)) : 8'($urandom);
            run_job(c, r, m, 4'($urandom), $urandom_range(0, 70), $urandom_range(0, 11) == 0,
                    $urandom_range(0, 3), e, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit: got %0d checks, required completion", n_checks);
        $fatal(1, "time limit");
    end

endmodule
